// File: rtl/muldiv_seq.sv
// muldiv_seq: HI/LO owner, sequential shift-add multiply / restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID,
  input  logic [5:0]       FUNCT,
  input  logic [WIDTH-1:0] RDATA1,
  input  logic [WIDTH-1:0] RDATA2,
  input  logic             FLUSH,
  output logic             STALL,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] RDATA
);

  localparam int CW = $clog2(WIDTH);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opb;
  logic               neg_lo, neg_hi, is_div;

  logic f_mfhi, f_mthi, f_mflo, f_mtlo;
  logic f_mul, f_div, sgn, hilo, accept;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    f_mfhi = FUNCT == 6'h10;
    f_mthi = FUNCT == 6'h11;
    f_mflo = FUNCT == 6'h12;
    f_mtlo = FUNCT == 6'h13;
    f_mul  = FUNCT == 6'h18 || FUNCT == 6'h19;
    f_div  = FUNCT == 6'h1A || FUNCT == 6'h1B;
    sgn    = FUNCT == 6'h18 || FUNCT == 6'h1A;
    hilo   = f_mfhi | f_mthi | f_mflo | f_mtlo | f_mul | f_div;
  end

  assign BUSY   = state != IDLE;
  assign STALL  = VALID & hilo & BUSY;
  assign accept = VALID & hilo & ~BUSY & ~FLUSH;
  assign RDATA  = f_mfhi ? HI : f_mflo ? LO : '0;

  assign a_neg = sgn & RDATA1[WIDTH-1];
  assign b_neg = sgn & RDATA2[WIDTH-1];
  assign a_mag = a_neg ? -RDATA1 : RDATA1;
  assign b_mag = b_neg ? -RDATA2 : RDATA2;

  // one iteration of each algorithm
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opb};
    div_diff = div_sh[WIDTH-1:0] - opb;
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_lo ? -prod : prod;
    q_fix    = neg_lo ? -acc_lo : acc_lo;
    r_fix    = neg_hi ? -acc_hi : acc_hi;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  always_comb begin
    ext_a     = {{WIDTH{a_neg}}, RDATA1};
    ext_b     = {{WIDTH{b_neg}}, RDATA2};
    fast_prod = ext_a * ext_b;
  end
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept && f_mul && !FAST_MUL) state_nx = MUL;
        else if (accept && f_div)         state_nx = DIV;
      end
      MUL, DIV: if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (FLUSH) state_nx = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_div <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          if (f_mthi) HI <= RDATA2;
          if (f_mtlo) LO <= RDATA2;
          if (f_mul || f_div) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= a_mag;
            opb    <= b_mag;
            is_div <= f_div;
            // x/0 keeps an all-ones quotient regardless of sign
            neg_lo <= (a_neg ^ b_neg) & ~(f_div & (RDATA2 == '0));
            neg_hi <= f_div ? a_neg : (a_neg ^ b_neg);
          end
`ifdef MULDIV_FAST_MUL_EN
          if (f_mul) begin
            {HI, LO} <= fast_prod;
            DONE     <= 1'b1;
          end
`endif
        end
        MUL: if (!FLUSH) begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
        end
        DIV: if (!FLUSH) begin
          acc_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + CW'(1);
        end
        FIX: if (!FLUSH) begin
          if (is_div) begin
            HI <= r_fix;
            LO <= q_fix;
          end else begin
            {HI, LO} <= prod_fix;
          end
          DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table + scoreboard for muldiv_seq.
// Honours MULDIV_FAST_MUL_EN for multiply latency expectations.
module tb_muldiv_seq;

  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12;
  localparam logic [5:0] MTLO = 6'h13, MULT = 6'h18, MULTU = 6'h19;
  localparam logic [5:0] DIVS = 6'h1A, DIVU = 6'h1B;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, VALID, FLUSH;
  logic [5:0]  FUNCT;
  logic [31:0] RDATA1, RDATA2;
  logic        STALL, BUSY, DONE;
  logic [31:0] HI, LO, RDATA;

  muldiv_seq #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .VALID(VALID), .FUNCT(FUNCT),
    .RDATA1(RDATA1), .RDATA2(RDATA2), .FLUSH(FLUSH),
    .STALL(STALL), .BUSY(BUSY), .DONE(DONE),
    .HI(HI), .LO(LO), .RDATA(RDATA)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void model(input logic [5:0] f,
      input logic [31:0] a, input logic [31:0] b,
      output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sp;
    logic [63:0] up;
    hi = '0;
    lo = '0;
    case (f)
      MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {hi, lo} = sp;
      end
      MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      DIVS: begin
        if (b == 0) begin
          lo = '1; hi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          lo = a; hi = '0;
        end else begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
        end
      end
      DIVU: begin
        if (b == 0) begin
          lo = '1; hi = a;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [5:0] f,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] eh, input logic [31:0] el, input bit b2b);
    int cyc;
    int bcnt;
    int exp_busy;
    exp_t e;
    sbq.push_back('{nm, eh, el});
    exp_busy = (FAST && (f == MULT || f == MULTU)) ? 0 : 33;
    VALID = 1'b1; FUNCT = f; RDATA1 = a; RDATA2 = b;
    tick();
    VALID = 1'b0; FUNCT = 6'h00;
    cyc = 0; bcnt = 0;
    while (!DONE && cyc < 40) begin
      if (BUSY) bcnt++;
      tick();
      cyc++;
    end
    chk({nm, "_done"}, 32'(DONE), 32'd1);
    chk({nm, "_busycyc"}, 32'(bcnt), 32'(exp_busy));
    e = sbq.pop_front();
    chk({e.name, "_hi"}, HI, e.hi);
    chk({e.name, "_lo"}, LO, e.lo);
    if (!b2b) begin
      tick();
      chk({nm, "_donepulse"}, 32'(DONE), 32'd0);
    end
  endtask

  task automatic move(input logic [5:0] f, input logic [31:0] v);
    VALID = 1'b1; FUNCT = f; RDATA2 = v;
    tick();
    VALID = 1'b0; FUNCT = 6'h00;
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] eh, el, ra, rb;
    logic [5:0]  rf;

    vecs.push_back('{"mult_m3x5",  MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{"div_m7_2",   DIVS,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_big_2", DIVU,  32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC});
    vecs.push_back('{"divu_dz",    DIVU,  32'd1234,     32'd0,        32'h000004D2, 32'hFFFFFFFF});
    vecs.push_back('{"div_dz_neg", DIVS,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});
    vecs.push_back('{"multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1});
    vecs.push_back('{"mult_min2",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0});
    vecs.push_back('{"div_7_m2",   DIVS,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{"mult_zero",  MULT,  32'd0,        32'hFFFFFFFF, 32'd0,        32'd0});

    RST = 1'b1; VALID = 1'b1; FUNCT = MTHI; FLUSH = 1'b0;
    RDATA1 = '0; RDATA2 = 32'hFFFF;
    tick();
    tick();
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    FUNCT = MFHI;
    #1;
    chk("rst_stall", 32'(STALL), 32'd0);
    RST = 1'b0; VALID = 1'b0;
    tick();

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rf = 6'h18 + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      model(rf, ra, rb, eh, el);
      run_op($sformatf("rand%0d", i), rf, ra, rb, eh, el, 1'b0);
    end

    // stall behind an in-flight multiply
    sbq.push_back('{"stall_mfhi", 32'd1, 32'd0});
    VALID = 1'b1; FUNCT = MULTU; RDATA1 = 32'h10000; RDATA2 = 32'h10000;
    tick();
    FUNCT = MFHI;
    #1;
    n = 0;
    while (STALL && n < 40) begin
      n++;
      tick();
    end
    chk("stall_cycles", 32'(n), FAST ? 32'd0 : 32'd33);
    chk("stall_done", 32'(DONE), 32'd1);
    begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.name, "_rdata"}, RDATA, e.hi);
      chk({e.name, "_lo"}, LO, e.lo);
    end
    tick();
    VALID = 1'b0; FUNCT = 6'h00;

    // flush mid divide
    move(MTHI, 32'h12345678);
    move(MTLO, 32'hCAFEBABE);
    VALID = 1'b1; FUNCT = MFLO;
    #1;
    chk("mflo_rdata", RDATA, 32'hCAFEBABE);
    FUNCT = DIVS; RDATA1 = 32'd100; RDATA2 = 32'd7;
    tick();
    VALID = 1'b0; FUNCT = 6'h00;
    repeat (9) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_busy", 32'(BUSY), 32'd0);
    chk("flush_lo", LO, 32'hCAFEBABE);
    chk("flush_hi", HI, 32'h12345678);
    chk("flush_done", 32'(DONE), 32'd0);
    repeat (30) tick();
    chk("flush_nodone", 32'(DONE), 32'd0);

    // reset mid divide
    VALID = 1'b1; FUNCT = DIVS; RDATA1 = 32'd100; RDATA2 = 32'd7;
    tick();
    VALID = 1'b0; FUNCT = 6'h00;
    repeat (19) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // flush on the fix edge
    move(MTHI, 32'h1111);
    move(MTLO, 32'h2222);
    VALID = 1'b1; FUNCT = DIVU; RDATA1 = 32'd50; RDATA2 = 32'd5;
    tick();
    VALID = 1'b0; FUNCT = 6'h00;
    repeat (32) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fixflush_done", 32'(DONE), 32'd0);
    chk("fixflush_hi", HI, 32'h1111);
    chk("fixflush_lo", LO, 32'h2222);
    chk("fixflush_busy", 32'(BUSY), 32'd0);

    // flush in idle suppresses accept
    FLUSH = 1'b1;
    move(MTHI, 32'hDEAD);
    chk("idleflush_hi", HI, 32'h1111);
    VALID = 1'b1; FUNCT = DIVU; RDATA1 = 32'd9; RDATA2 = 32'd3;
    tick();
    VALID = 1'b0; FUNCT = 6'h00; FLUSH = 1'b0;
    chk("idleflush_busy", 32'(BUSY), 32'd0);

    // overflow then back-to-back accept
    run_op("div_ovf", DIVS, 32'h80000000, 32'hFFFFFFFF,
           32'd0, 32'h80000000, 1'b1);
    run_op("divu_b2b", DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
